// File: rtl/timer_pkg.sv
// Shared defines for the timer peripheral: register offsets, CTRL bit indices,
// bus/reset constants and the offset decoder used by the top level.
package timer_pkg;

  localparam logic [3:0] TIMER_CTRL   = 4'h0;
  localparam logic [3:0] TIMER_VALUE  = 4'h4;
  localparam logic [3:0] TIMER_EXPIRE = 4'h8;
  localparam logic [3:0] TIMER_PRESC  = 4'hC;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IE      = 1;
  localparam int CTRL_PENDING = 2;

  localparam int          INT_TIMER0  = 0;
  localparam logic        RstEnable   = 1'b0;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_CTRL,
    SEL_VALUE,
    SEL_EXPIRE,
    SEL_PRESC
  } reg_sel_e;

  typedef struct packed {
    logic     hit;
    reg_sel_e sel;
  } reg_dec_t;

  // Misaligned offsets are treated as unmapped so they neither read nor write.
  function automatic reg_dec_t decode_addr(input logic [3:0] offs);
    reg_dec_t d;
    d.hit = 1'b1;
    d.sel = SEL_CTRL;
    case (offs)
      TIMER_CTRL:   d.sel = SEL_CTRL;
      TIMER_VALUE:  d.sel = SEL_VALUE;
      TIMER_EXPIRE: d.sel = SEL_EXPIRE;
      TIMER_PRESC:  d.sel = SEL_PRESC;
      default:      d.hit = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/timer_presc.sv
// Prescaler for the timer: counts 0..presc while enabled and flags the
// terminal cycle as a tick.
module timer_presc
  import timer_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt;

  assign tick = en && (pcnt == presc);

  // A PRESC rewrite restarts the division so the new ratio applies cleanly.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pcnt <= '0;
    end else if (clr || !en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer.sv
// Memory-mapped 32-bit timer with prescaler and compare match; int_sig_o is
// the level interrupt request feeding INT_TIMER0 of the core.
module timer
  import timer_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        int_sig_o
);

  logic               en;
  logic               ie;
  logic               pending;
  logic [31:0]        count;
  logic [31:0]        expire;
  logic [PRESC_W-1:0] presc;

  reg_dec_t dec;
  logic     wr;
  logic     wr_ctrl;
  logic     wr_value;
  logic     wr_expire;
  logic     wr_presc;
  logic     tick;
  logic     match;
  logic     unused_addr;

  assign dec         = decode_addr(addr_i[3:0]);
  assign unused_addr = ^addr_i[31:4];

  assign wr        = req_i && (we_i == WriteEnable) && dec.hit;
  assign wr_ctrl   = wr && (dec.sel == SEL_CTRL);
  assign wr_value  = wr && (dec.sel == SEL_VALUE);
  assign wr_expire = wr && (dec.sel == SEL_EXPIRE);
  assign wr_presc  = wr && (dec.sel == SEL_PRESC);

  timer_presc #(
    .PRESC_W(PRESC_W)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (wr_presc),
    .presc(presc),
    .tick (tick)
  );

  // An EXPIRE of zero disables matching so the counter free-runs and wraps.
  assign match = tick && (expire != ZeroWord) && (count == expire);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      en     <= 1'b0;
      ie     <= 1'b0;
      expire <= ZeroWord;
      presc  <= '0;
    end else begin
      if (wr_ctrl) begin
        en <= data_i[CTRL_EN];
        ie <= data_i[CTRL_IE];
      end
      if (wr_expire) begin
        expire <= data_i;
      end
      if (wr_presc) begin
        presc <= data_i[PRESC_W-1:0];
      end
    end
  end

  // A software load of VALUE wins over the tick and suppresses that cycle's match.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      count <= ZeroWord;
    end else if (wr_value) begin
      count <= data_i;
    end else if (tick) begin
      count <= match ? ZeroWord : count + 32'd1;
    end
  end

  // Hardware set is checked first so an expiry racing a W1C is never dropped.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pending <= 1'b0;
    end else if (match && !wr_value) begin
      pending <= 1'b1;
    end else if (wr_ctrl && data_i[CTRL_PENDING]) begin
      pending <= 1'b0;
    end
  end

  always_comb begin
    data_o = ZeroWord;
    if (req_i && dec.hit) begin
      case (dec.sel)
        SEL_CTRL:   data_o = {29'd0, pending, ie, en};
        SEL_VALUE:  data_o = count;
        SEL_EXPIRE: data_o = expire;
        SEL_PRESC:  data_o[PRESC_W-1:0] = presc;
        default:    data_o = ZeroWord;
      endcase
    end
  end

  assign int_sig_o = pending & ie;

endmodule

// File: tb/tb_timer.sv
// Directed self-checking bench for the timer peripheral; inputs change and
// outputs are sampled on the falling clock edge.
module tb_timer;

  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_VALUE  = 32'h4;
  localparam logic [31:0] A_EXPIRE = 32'h8;
  localparam logic [31:0] A_PRESC  = 32'hC;

  logic        clk;
  logic        rst;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        int_sig_o;

  int n_checks;
  int n_fail;

  timer #(.PRESC_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .data_o   (data_o),
    .int_sig_o(int_sig_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called on a falling edge; the write lands on the next rising edge and
  // the task returns on the falling edge after it.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    req_i  = 1'b1;
    we_i   = 1'b1;
    addr_i = a;
    data_i = d;
    @(negedge clk);
    req_i  = 1'b0;
    we_i   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = a;
    #1;
    d = data_o;
    req_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] addrs [4];
    addrs = '{A_CTRL, A_VALUE, A_EXPIRE, A_PRESC};
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_read(addrs[i], rd);
      n_checks++;
      if (rd !== 32'h0) begin
        n_fail++;
        $display("[TB] FAIL reset_read[%0h]: got %h expected %h", addrs[i], rd, 32'h0);
      end
    end
    n_checks++;
    if (int_sig_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_int: got %b expected 0", int_sig_o);
    end
  endtask

  task automatic test_compare();
    logic [31:0] rd;
    logic [31:0] exp_v;
    bus_write(A_PRESC, 32'd0);
    bus_write(A_EXPIRE, 32'd3);
    bus_write(A_CTRL, 32'h3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_v = (k == 4) ? 32'd0 : 32'(k);
      bus_read(A_VALUE, rd);
      n_checks++;
      if (rd !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL cmp_value[%0d]: got %h expected %h", k, rd, exp_v);
      end
      n_checks++;
      if (int_sig_o !== (k == 4)) begin
        n_fail++;
        $display("[TB] FAIL cmp_int[%0d]: got %b expected %b", k, int_sig_o, (k == 4));
      end
    end
    bus_write(A_CTRL, 32'h7);
    bus_read(A_VALUE, rd);
    n_checks++;
    if (int_sig_o !== 1'b0 || rd !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL cmp_clear: got int=%b value=%h expected int=0 value=1", int_sig_o, rd);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (int_sig_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL cmp_period_early: got %b expected 0", int_sig_o);
    end
    @(negedge clk);
    n_checks++;
    if (int_sig_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL cmp_period: got %b expected 1", int_sig_o);
    end
  endtask

  task automatic test_w1c_race();
    logic [31:0] rd;
    bus_write(A_CTRL, 32'h7);
    n_checks++;
    if (int_sig_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL race_preclear: got %b expected 0", int_sig_o);
    end
    repeat (2) @(negedge clk);
    bus_write(A_CTRL, 32'h7);
    bus_read(A_VALUE, rd);
    n_checks++;
    if (int_sig_o !== 1'b1 || rd !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL race_w1c: got int=%b value=%h expected int=1 value=0", int_sig_o, rd);
    end
    bus_write(A_CTRL, 32'h4);
    repeat (3) @(negedge clk);
    bus_read(A_VALUE, rd);
    n_checks++;
    if (rd !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL race_hold: got %h expected %h", rd, 32'd1);
    end
    bus_read(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL race_ctrl: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_prescaler();
    logic [31:0] rd;
    logic [31:0] exp_v;
    bus_write(A_PRESC, 32'd2);
    bus_write(A_EXPIRE, 32'd1);
    bus_write(A_VALUE, 32'd0);
    bus_write(A_CTRL, 32'h3);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_v = (k >= 3 && k < 6) ? 32'd1 : 32'd0;
      bus_read(A_VALUE, rd);
      n_checks++;
      if (rd !== exp_v || int_sig_o !== (k == 6)) begin
        n_fail++;
        $display("[TB] FAIL presc_step[%0d]: got value=%h int=%b expected value=%h int=%b",
                 k, rd, int_sig_o, exp_v, (k == 6));
      end
    end
    bus_write(A_CTRL, 32'h7);
    repeat (4) @(negedge clk);
    n_checks++;
    if (int_sig_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL presc_period_early: got %b expected 0", int_sig_o);
    end
    @(negedge clk);
    n_checks++;
    if (int_sig_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL presc_period: got %b expected 1", int_sig_o);
    end
    bus_write(A_CTRL, 32'h4);
  endtask

  task automatic test_bus_decode();
    logic [31:0] rd;
    bus_write(A_EXPIRE, 32'h55);
    req_i  = 1'b0;
    we_i   = 1'b0;
    addr_i = A_EXPIRE;
    #1;
    n_checks++;
    if (data_o !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL dec_noreq: got %h expected %h", data_o, 32'h0);
    end
    bus_read(32'hA, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL dec_unmapped_read: got %h expected %h", rd, 32'h0);
    end
    @(negedge clk);
    bus_write(32'h9, 32'hFFFF_FFFF);
    bus_read(A_EXPIRE, rd);
    n_checks++;
    if (rd !== 32'h55) begin
      n_fail++;
      $display("[TB] FAIL dec_unmapped_write: got %h expected %h", rd, 32'h55);
    end
    bus_write(A_PRESC, 32'hFFFF_FFFF);
    bus_read(A_PRESC, rd);
    n_checks++;
    if (rd !== 32'hFF) begin
      n_fail++;
      $display("[TB] FAIL dec_presc_width: got %h expected %h", rd, 32'hFF);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    logic [31:0] exp_seq [2];
    exp_seq = '{32'hFFFF_FFFF, 32'h0};
    bus_write(A_PRESC, 32'd0);
    bus_write(A_EXPIRE, 32'd0);
    bus_write(A_VALUE, 32'hFFFF_FFFE);
    bus_write(A_CTRL, 32'h3);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus_read(A_VALUE, rd);
      n_checks++;
      if (rd !== exp_seq[k]) begin
        n_fail++;
        $display("[TB] FAIL wrap_value[%0d]: got %h expected %h", k, rd, exp_seq[k]);
      end
    end
    bus_read(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h3 || int_sig_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wrap_nopending: got ctrl=%h int=%b expected ctrl=3 int=0", rd, int_sig_o);
    end
    @(negedge clk);
    bus_write(A_VALUE, 32'h10);
    bus_read(A_VALUE, rd);
    n_checks++;
    if (rd !== 32'h10) begin
      n_fail++;
      $display("[TB] FAIL load_in_tick: got %h expected %h", rd, 32'h10);
    end
    @(negedge clk);
    bus_read(A_VALUE, rd);
    n_checks++;
    if (rd !== 32'h11) begin
      n_fail++;
      $display("[TB] FAIL load_then_count: got %h expected %h", rd, 32'h11);
    end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] rd;
    logic [31:0] addrs [4];
    addrs = '{A_CTRL, A_VALUE, A_EXPIRE, A_PRESC};
    bus_write(A_EXPIRE, 32'd2);
    bus_write(A_VALUE, 32'd0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (int_sig_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_pending: got %b expected 1", int_sig_o);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_checks++;
    if (int_sig_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_int_drop: got %b expected 0", int_sig_o);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(addrs[i], rd);
      n_checks++;
      if (rd !== 32'h0) begin
        n_fail++;
        $display("[TB] FAIL mid_reset_read[%0h]: got %h expected %h", addrs[i], rd, 32'h0);
      end
    end
    repeat (3) @(negedge clk);
    bus_read(A_VALUE, rd);
    n_checks++;
    if (rd !== 32'h0 || int_sig_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_stays_idle: got value=%h int=%b expected 0/0", rd, int_sig_o);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    req_i    = 1'b0;
    we_i     = 1'b0;
    addr_i   = 32'h0;
    data_i   = 32'h0;
    @(negedge clk);
    test_reset();
    test_compare();
    test_w1c_race();
    test_prescaler();
    test_bus_decode();
    test_wrap();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer.md
# timer

Memory-mapped 32-bit timer peripheral with programmable prescaler and compare match, producing the timer interrupt request that the core-local interruptor samples as an asynchronous interrupt source. It sits on the peripheral bus as a slave, and its `int_sig_o` drives bit 0 (`INT_TIMER0`) of the core's interrupt flag bus. Software clears the pending flag in the trap handler before `mret`.

## Interface
Parameters:
- `PRESC_W`, default 8: prescaler width; divide ratio is `presc + 1`.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low (`RstEnable` = 0).
- `req_i`  in  1  bus access valid this cycle.
- `we_i`  in  1  write strobe; qualified by `req_i`.
- `addr_i`  in  32  byte address; only `addr_i[3:0]` decoded, word aligned.
- `data_i`  in  32  write data.
- `data_o`  out  32  read data, combinational from `addr_i`; zero when `req_i`=0 or the address is unmapped.
- `int_sig_o`  out  1  interrupt request, level, = `pending & ie`.

## Operation
Register map (offsets):
- 0x0: CTRL.
  - bit0 `en`: count enable, RW.
  - bit1 `ie`: interrupt enable, RW.
  - bit2 `pending`: RO, write-1-to-clear.
  - bits[31:3] read 0.
- 0x4: VALUE. Current count, RW.
- 0x8: EXPIRE. Compare value, RW.
- 0xC: PRESC. bits[PRESC_W-1:0] RW; upper bits read 0.

Prescaler:
- `pcnt` counts 0..`presc` while `en`=1.
- A tick is the cycle with `en`=1 and `pcnt == presc`. On a tick, `pcnt` returns to 0.
- `en`=0 forces `pcnt` to 0. `count` holds its value.

Counter, evaluated on a tick:
- If `expire != 0` and `count == expire`: `count` <= 0 and `pending` <= 1.
- Otherwise: `count` <= `count + 1`, mod 2^32.
- With `expire` = 0, no match ever fires and `count` wraps 0xFFFF_FFFF -> 0 silently.

Precedence and simultaneous events:
- A VALUE write beats the tick update in the same cycle. The written value is loaded and no match is evaluated that cycle.
- A hardware set of `pending` beats a software W1C in the same cycle, so a new expiry is never lost.
- CTRL write with bit2=0 leaves `pending` unchanged.
- Writing CTRL `en` 1->0 in a tick cycle: the tick still applies that cycle, then counting stops.
- PRESC write: `pcnt` <= 0 in the same cycle.
- Unmapped writes are ignored.

Reset (`rst`=0 at a clock edge):
- All registers and `pcnt` go to 0, so `int_sig_o` = 0 and `data_o` = 0.
- Reset applied mid-count aborts the count immediately. No interrupt is emitted.

## Timing
- Register writes take effect at the edge that samples `req_i & we_i`. Readback is correct from the next cycle.
- With `presc`=0: enabling at edge N produces the first increment at edge N+1, and `count` = k after edge N+k.
- Match: the edge where `count == expire` on a tick sets `pending`, and `int_sig_o` rises in the following cycle. Interrupt period is `(expire + 1) * (presc + 1)` cycles.
- `int_sig_o` falls in the cycle after a W1C edge, or after `ie` is cleared.
- There are no wait states; every access completes in one cycle.

## Structure
- Offsets `TIMER_CTRL` / `VALUE` / `EXPIRE` / `PRESC` and CTRL bit indices go in the shared defines file beside `INT_TIMER0`, `RstEnable`, `WriteEnable`, and `ZeroWord`.
- One natural sub-module is `timer_presc`: the prescaler counter, taking `en` and `presc` and emitting `tick`. The bus decode, counter, and pending logic stay in `timer`.

## Test plan
- Reset, then read all four offsets -> each reads 0, and `int_sig_o` = 0.
- Program PRESC=0, EXPIRE=3, CTRL=0x3 -> `pending` sets 4 cycles after `en` rises, `int_sig_o` is high the cycle after, VALUE reads 0, and the interrupt repeats every 4 cycles.
- Program PRESC=2, EXPIRE=1 -> VALUE increments every 3 cycles, and the interrupt period is 6 cycles.
- Issue a W1C of CTRL bit2 in the exact cycle of a match -> `pending` remains 1.
- Write VALUE=0xFFFF_FFFE with EXPIRE=0 and `en`=1 -> VALUE wraps to 0 after two ticks with no `pending`. Then write VALUE=0x10 in a tick cycle -> it reads 0x10.
- Hold `rst`=0 for one edge mid-count with `pending`=1 -> all registers return to 0, and `int_sig_o` drops the next cycle.
